// File: rtl/regfile_op_sequencer.sv
// Multicycle ALU-op sequencer for a 2R/1W register file.
// Accept, read operands, execute, write back: one command per four cycles.
module regfile_op_sequencer #(
   parameter int REG_WIDTH     = 16,
   parameter int REG_ADDR_BITS = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [3:0]               cmd_op,
   input  logic [REG_ADDR_BITS-1:0] cmd_rdest,
   input  logic [REG_ADDR_BITS-1:0] cmd_rsrc,
   input  logic                     cmd_use_imm,
   input  logic [7:0]               cmd_imm,
   output logic [REG_ADDR_BITS-1:0] regAddress1,
   output logic [REG_ADDR_BITS-1:0] regAddress2,
   input  logic [REG_WIDTH-1:0]     regReadData1,
   input  logic [REG_WIDTH-1:0]     regReadData2,
   output logic                     regWriteEnable,
   output logic [REG_WIDTH-1:0]     regWriteData,
   output logic                     done,
   output logic                     err,
   output logic [3:0]               flags
);

   localparam int MSB = REG_WIDTH - 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_EXEC,
      S_WRITE
   } state_t;

   state_t                   state_q;
   logic [3:0]               op_q;
   logic [REG_ADDR_BITS-1:0] addr1_q;
   logic [REG_ADDR_BITS-1:0] addr2_q;
   logic                     use_imm_q;
   logic [7:0]               imm_q;
   logic [MSB:0]             a_q;
   logic [MSB:0]             b_q;
   logic [MSB:0]             res_q;
   logic                     ready_q;
   logic                     we_q;
   logic                     done_q;
   logic                     err_q;
   logic [3:0]               flags_q;

   logic [MSB:0]             imm_ext;
   logic [MSB:0]             b_d;
   logic [REG_WIDTH:0]       sum;
   logic [MSB:0]             diff;
   logic [MSB:0]             res_d;
   logic                     c_d;
   logic                     f_d;
   logic                     wr_d;
   logic                     ill_d;
   logic [3:0]               flags_d;

   assign imm_ext = {{(REG_WIDTH-8){imm_q[7]}}, imm_q};
   assign b_d     = use_imm_q ? imm_ext : regReadData2;
   assign sum     = {1'b0, a_q} + {1'b0, b_q};
   assign diff    = a_q - b_q;

   // ALU result, write-back decision and next flags for the latched op
   always_comb begin
      res_d = a_q;
      c_d   = flags_q[3];
      f_d   = flags_q[2];
      wr_d  = 1'b0;
      ill_d = 1'b0;
      unique case (op_q)
         4'd0: begin
            res_d = sum[MSB:0];
            c_d   = sum[REG_WIDTH];
            f_d   = (a_q[MSB] == b_q[MSB]) &&
                    (sum[MSB] != a_q[MSB]);
            wr_d  = 1'b1;
         end
         4'd1, 4'd7: begin
            res_d = diff;
            c_d   = a_q < b_q;
            f_d   = (a_q[MSB] != b_q[MSB]) &&
                    (diff[MSB] != a_q[MSB]);
            wr_d  = (op_q == 4'd1);
         end
         4'd2: begin
            res_d = a_q & b_q;
            wr_d  = 1'b1;
         end
         4'd3: begin
            res_d = a_q | b_q;
            wr_d  = 1'b1;
         end
         4'd4: begin
            res_d = a_q ^ b_q;
            wr_d  = 1'b1;
         end
         4'd5: begin
            res_d = b_q;
            wr_d  = 1'b1;
         end
         4'd6: begin
            res_d = a_q << b_q[3:0];
            wr_d  = 1'b1;
         end
         default: begin
            ill_d = 1'b1;
         end
      endcase
      flags_d = ill_d ? flags_q :
                {c_d, f_d, (res_d == '0), res_d[MSB]};
   end

   // Sequencer FSM with registered handshake, strobes and addresses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         addr1_q   <= '0;
         addr2_q   <= '0;
         use_imm_q <= 1'b0;
         imm_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
         ready_q   <= 1'b1;
         we_q      <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         flags_q   <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  op_q      <= cmd_op;
                  addr1_q   <= cmd_rdest;
                  addr2_q   <= cmd_rsrc;
                  use_imm_q <= cmd_use_imm;
                  imm_q     <= cmd_imm;
                  ready_q   <= 1'b0;
                  state_q   <= S_READ;
               end
            end
            S_READ: begin
               a_q     <= regReadData1;
               b_q     <= b_d;
               state_q <= S_EXEC;
            end
            S_EXEC: begin
               res_q   <= res_d;
               we_q    <= wr_d;
               done_q  <= 1'b1;
               err_q   <= ill_d;
               flags_q <= flags_d;
               state_q <= S_WRITE;
            end
            S_WRITE: begin
               we_q    <= 1'b0;
               done_q  <= 1'b0;
               err_q   <= 1'b0;
               addr1_q <= '0;
               addr2_q <= '0;
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready      = ready_q;
   assign regAddress1    = addr1_q;
   assign regAddress2    = addr2_q;
   assign regWriteEnable = we_q;
   assign regWriteData   = res_q;
   assign done           = done_q;
   assign err            = err_q;
   assign flags          = flags_q;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Bench for regfile_op_sequencer: directed scenarios plus
// randomized commands against a behavioural register-file model.
module tb_regfile_op_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_op = '0;
   logic [3:0]  cmd_rdest = '0;
   logic [3:0]  cmd_rsrc = '0;
   logic        cmd_use_imm = 1'b0;
   logic [7:0]  cmd_imm = '0;
   logic [3:0]  regAddress1;
   logic [3:0]  regAddress2;
   logic [15:0] regReadData1;
   logic [15:0] regReadData2;
   logic        regWriteEnable;
   logic [15:0] regWriteData;
   logic        done;
   logic        err;
   logic [3:0]  flags;

   logic [15:0] rf [16];
   int          vectors = 0;
   int          miscompares = 0;
   int          wr_total = 0;
   logic [3:0]  mflags = '0;

   int          obs_lat;
   int          obs_w;
   int          obs_done;
   int          obs_err;
   logic [3:0]  obs_a1;
   logic [3:0]  obs_a2;
   logic [7:0]  obs_idle_a;

   always #5 clk = ~clk;

   regfile_op_sequencer #(
      .REG_WIDTH(16),
      .REG_ADDR_BITS(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op(cmd_op),
      .cmd_rdest(cmd_rdest),
      .cmd_rsrc(cmd_rsrc),
      .cmd_use_imm(cmd_use_imm),
      .cmd_imm(cmd_imm),
      .regAddress1(regAddress1),
      .regAddress2(regAddress2),
      .regReadData1(regReadData1),
      .regReadData2(regReadData2),
      .regWriteEnable(regWriteEnable),
      .regWriteData(regWriteData),
      .done(done),
      .err(err),
      .flags(flags)
   );

   assign regReadData1 = rf[regAddress1];
   assign regReadData2 = rf[regAddress2];

   always @(posedge clk) begin
      if (regWriteEnable) begin
         rf[regAddress1] <= regWriteData;
         wr_total <= wr_total + 1;
      end
   end

   // Reference: operation semantics from plain integer arithmetic
   function automatic void model(input logic [3:0] op,
                                 input logic [15:0] a,
                                 input logic [15:0] b,
                                 input logic [3:0] fin,
                                 output logic [15:0] res,
                                 output logic [3:0] fout,
                                 output bit wr,
                                 output bit ill);
      int sa;
      int sb;
      int s;
      int u;
      sa = int'($signed(a));
      sb = int'($signed(b));
      res = a;
      fout = fin;
      wr = 1'b0;
      ill = 1'b0;
      case (op)
         4'd0: begin
            u = int'(a) + int'(b);
            res = 16'(u);
            fout[3] = (u > 65535);
            s = sa + sb;
            fout[2] = (s > 32767) || (s < -32768);
            wr = 1'b1;
         end
         4'd1, 4'd7: begin
            u = int'(a) - int'(b);
            res = 16'(u);
            fout[3] = (int'(a) < int'(b));
            s = sa - sb;
            fout[2] = (s > 32767) || (s < -32768);
            wr = (op == 4'd1);
         end
         4'd2: begin res = a & b; wr = 1'b1; end
         4'd3: begin res = a | b; wr = 1'b1; end
         4'd4: begin res = a ^ b; wr = 1'b1; end
         4'd5: begin res = b; wr = 1'b1; end
         4'd6: begin
            u = int'(a) * (1 << int'(b[3:0]));
            res = 16'(u);
            wr = 1'b1;
         end
         default: ill = 1'b1;
      endcase
      if (!ill) begin
         fout[1] = (res == 16'h0000);
         fout[0] = res[15];
      end
   endfunction

   // Issue one command and observe the following six cycles
   task automatic run_cmd(input logic [3:0] op, input logic [3:0] rd,
                          input logic [3:0] rs, input logic ui,
                          input logic [7:0] imm);
      int n;
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_rdest = rd;
      cmd_rsrc = rs;
      cmd_use_imm = ui;
      cmd_imm = imm;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op = 4'($urandom);
      cmd_rdest = 4'($urandom);
      cmd_rsrc = 4'($urandom);
      cmd_imm = 8'($urandom);
      obs_lat = 0;
      obs_w = 0;
      obs_done = 0;
      obs_err = 0;
      obs_a1 = regAddress1;
      obs_a2 = regAddress2;
      for (int i = 1; i <= 6; i++) begin
         if (i > 1) @(negedge clk);
         if (done) begin
            obs_done++;
            if (obs_lat == 0) obs_lat = i;
         end
         if (regWriteEnable) obs_w++;
         if (err) obs_err++;
      end
      obs_idle_a = {regAddress1, regAddress2};
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2 reset = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if (cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ready got %b exp 1", cmd_ready);
      end
      vectors++;
      if ({regWriteEnable, done, err, flags, regAddress1, regAddress2}
          !== 15'h0) begin
         miscompares++;
         $display("FAIL reset_outs got we%b d%b e%b f%h a%h/%h exp 0",
                  regWriteEnable, done, err, flags, regAddress1, regAddress2);
      end
      reset = 1'b1;
      mflags = '0;
      @(negedge clk);
   endtask

   task automatic test_add();
      rf[1] = 16'h7FFF;
      rf[2] = 16'h0001;
      run_cmd(4'd0, 4'd1, 4'd2, 1'b0, 8'h00);
      vectors++;
      if (obs_a1 !== 4'd1 || obs_a2 !== 4'd2) begin
         miscompares++;
         $display("FAIL add_addr got %h/%h exp 1/2", obs_a1, obs_a2);
      end
      vectors++;
      if (obs_lat !== 3 || obs_done !== 1 || obs_w !== 1) begin
         miscompares++;
         $display("FAIL add_timing got lat%0d d%0d w%0d exp lat3 d1 w1",
                  obs_lat, obs_done, obs_w);
      end
      vectors++;
      if (rf[1] !== 16'h8000) begin
         miscompares++;
         $display("FAIL add_result got %h exp 8000", rf[1]);
      end
      vectors++;
      if (flags !== 4'b0101) begin
         miscompares++;
         $display("FAIL add_flags got %b exp 0101", flags);
      end
      vectors++;
      if (obs_idle_a !== 8'h00) begin
         miscompares++;
         $display("FAIL idle_addr got %h exp 00", obs_idle_a);
      end
      mflags = 4'b0101;
   endtask

   task automatic test_sub_imm();
      rf[3] = 16'h0005;
      run_cmd(4'd1, 4'd3, 4'd9, 1'b1, 8'hFF);
      vectors++;
      if (rf[3] !== 16'h0006) begin
         miscompares++;
         $display("FAIL sub_imm_result got %h exp 0006", rf[3]);
      end
      vectors++;
      if (flags !== 4'b1000) begin
         miscompares++;
         $display("FAIL sub_imm_flags got %b exp 1000", flags);
      end
      mflags = 4'b1000;
   endtask

   task automatic test_cmp();
      rf[4] = 16'h1234;
      run_cmd(4'd7, 4'd4, 4'd4, 1'b0, 8'h00);
      vectors++;
      if (rf[4] !== 16'h1234 || obs_w !== 0 || obs_done !== 1) begin
         miscompares++;
         $display("FAIL cmp_nowrite got r4=%h w%0d d%0d exp 1234 w0 d1",
                  rf[4], obs_w, obs_done);
      end
      vectors++;
      if (flags !== 4'b0010) begin
         miscompares++;
         $display("FAIL cmp_flags got %b exp 0010", flags);
      end
      mflags = 4'b0010;
   endtask

   task automatic test_lsh_illegal();
      int w0;
      rf[5] = 16'h0001;
      rf[6] = 16'h0013;
      run_cmd(4'd6, 4'd5, 4'd6, 1'b0, 8'h00);
      vectors++;
      if (rf[5] !== 16'h0008 || flags !== 4'b0000) begin
         miscompares++;
         $display("FAIL lsh got r5=%h f%b exp 0008 f0000", rf[5], flags);
      end
      w0 = wr_total;
      run_cmd(4'hC, 4'd5, 4'd6, 1'b0, 8'h00);
      vectors++;
      if (obs_err !== 1 || obs_done !== 1 || obs_lat !== 3) begin
         miscompares++;
         $display("FAIL illegal_err got e%0d d%0d lat%0d exp e1 d1 lat3",
                  obs_err, obs_done, obs_lat);
      end
      vectors++;
      if (wr_total !== w0 || rf[5] !== 16'h0008 || flags !== 4'b0000) begin
         miscompares++;
         $display("FAIL illegal_side got w%0d r5=%h f%b exp w%0d 0008 0000",
                  wr_total, rf[5], flags, w0);
      end
      mflags = 4'b0000;
   endtask

   task automatic test_reset_mid();
      int w0;
      rf[10] = 16'h0000;
      run_cmd(4'd1, 4'd10, 4'd0, 1'b1, 8'h01);
      vectors++;
      if (flags !== 4'b1001 || rf[10] !== 16'hFFFF) begin
         miscompares++;
         $display("FAIL pre_reset got f%b r10=%h exp 1001 FFFF",
                  flags, rf[10]);
      end
      rf[8] = 16'h0001;
      rf[9] = 16'h0002;
      w0 = wr_total;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op = 4'd0;
      cmd_rdest = 4'd8;
      cmd_rsrc = 4'd9;
      cmd_use_imm = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      vectors++;
      if (cmd_ready !== 1'b1 || flags !== 4'b0000 || done !== 1'b0 ||
          regWriteEnable !== 1'b0 || regAddress1 !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_mid got rdy%b f%b d%b we%b a%h exp 1 0 0 0 0",
                  cmd_ready, flags, done, regWriteEnable, regAddress1);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if (wr_total !== w0 || rf[8] !== 16'h0001) begin
         miscompares++;
         $display("FAIL reset_abort got w%0d r8=%h exp w%0d 0001",
                  wr_total, rf[8], w0);
      end
      mflags = '0;
      run_cmd(4'd0, 4'd8, 4'd9, 1'b0, 8'h00);
      vectors++;
      if (rf[8] !== 16'h0003 || obs_lat !== 3 || flags !== 4'b0000) begin
         miscompares++;
         $display("FAIL post_reset got r8=%h lat%0d f%b exp 0003 3 0000",
                  rf[8], obs_lat, flags);
      end
   endtask

   task automatic test_back_to_back();
      int acc [3];
      int nacc;
      int ndone;
      rf[7] = 16'h0000;
      nacc = 0;
      ndone = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op = 4'd0;
      cmd_rdest = 4'd7;
      cmd_rsrc = 4'd0;
      cmd_use_imm = 1'b1;
      cmd_imm = 8'h01;
      for (int c = 0; c < 24; c++) begin
         if (c > 0) @(negedge clk);
         if (nacc == 3) cmd_valid = 1'b0;
         if (done) ndone++;
         if (cmd_valid && cmd_ready) begin
            acc[nacc] = c;
            nacc++;
         end
      end
      cmd_valid = 1'b0;
      vectors++;
      if (nacc !== 3 || ndone !== 3) begin
         miscompares++;
         $display("FAIL b2b_count got acc%0d done%0d exp 3 3", nacc, ndone);
      end else begin
         vectors++;
         if (acc[1] - acc[0] !== 4 || acc[2] - acc[1] !== 4) begin
            miscompares++;
            $display("FAIL b2b_spacing got %0d %0d exp 4 4",
                     acc[1] - acc[0], acc[2] - acc[1]);
         end
      end
      vectors++;
      if (rf[7] !== 16'h0003) begin
         miscompares++;
         $display("FAIL b2b_result got %h exp 0003", rf[7]);
      end
      mflags = 4'b0000;
   endtask

   task automatic test_random();
      logic [3:0]  op;
      logic [3:0]  rd;
      logic [3:0]  rs;
      logic        ui;
      logic [7:0]  imm;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic [15:0] exp_rd;
      logic [3:0]  fexp;
      bit          wr;
      bit          ill;
      for (int r = 0; r < 16; r++) rf[r] = 16'($urandom);
      for (int k = 0; k < 40; k++) begin
         op = 4'($urandom_range(0, 9));
         rd = 4'($urandom);
         rs = 4'($urandom);
         ui = 1'($urandom);
         imm = 8'($urandom);
         if ($urandom_range(0, 3) == 0) rf[rd] = 16'($urandom_range(0, 3));
         a = rf[rd];
         b = ui ? 16'(int'($signed(imm))) : rf[rs];
         model(op, a, b, mflags, res, fexp, wr, ill);
         exp_rd = wr ? res : a;
         run_cmd(op, rd, rs, ui, imm);
         vectors++;
         if (rf[rd] !== exp_rd || flags !== fexp) begin
            miscompares++;
            $display("FAIL rand%0d op%h got r=%h f%b exp r=%h f%b",
                     k, op, rf[rd], flags, exp_rd, fexp);
         end
         vectors++;
         if (obs_w !== int'(wr) || obs_err !== int'(ill) ||
             obs_done !== 1 || obs_lat !== 3) begin
            miscompares++;
            $display("FAIL rand%0d_ctl got w%0d e%0d d%0d lat%0d exp w%0d e%0d",
                     k, obs_w, obs_err, obs_done, obs_lat, wr, ill);
         end
         mflags = fexp;
      end
   endtask

   initial begin
      for (int r = 0; r < 16; r++) rf[r] = '0;
      test_reset();
      test_add();
      test_sub_imm();
      test_cmp();
      test_lsh_illegal();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
